// File: rtl/memory_bus_pkg.sv
// Shared widths and the request record for the MemoryBus arbiter.
package memory_bus_pkg;

  localparam int MS_ADDR_W = 30;
  localparam int MS_DATA_W = 24;
  localparam int MS_ID_W   = 8;
  localparam int AXI_ID_W  = 6;

  typedef struct packed {
    logic                 write;
    logic [MS_ADDR_W-1:0] addr;
    logic [MS_DATA_W-1:0] data;
    logic [MS_ID_W-1:0]   id;
  } req_t;

endpackage

// File: rtl/memory_bus_if.sv
// MemoryBus: ms* carries requests master->slave, sm* carries read responses back.
interface MemoryBus;

  logic                                  msValid;
  logic                                  msTaken;
  logic                                  msWrite;
  logic [memory_bus_pkg::MS_ADDR_W-1:0]  msAddress;
  logic [memory_bus_pkg::MS_DATA_W-1:0]  msData;
  logic [memory_bus_pkg::MS_ID_W-1:0]    msID;
  logic                                  smValid;
  logic                                  smTaken;
  logic [memory_bus_pkg::MS_DATA_W-1:0]  smData;
  logic [memory_bus_pkg::MS_ID_W-1:0]    smID;

  modport Master (
    output msValid, msWrite, msAddress, msData, msID, smTaken,
    input  msTaken, smValid, smData, smID
  );

endinterface

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Walk offsets from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        grant_idx   = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// N:1 round-robin MemoryBus arbiter with one request slot and one response slot.
// The source index is stamped into msID[5:CID_W]; read responses are routed back by it.
// Optional feature macro ARB_STATS_EN adds saturating grant/drop counters.
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int SRC_W     = $clog2(N_CLIENTS),
  parameter int CID_W     = AXI_ID_W - SRC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CLIENTS-1:0]           c_valid,
  output logic [N_CLIENTS-1:0]           c_taken,
  input  logic [N_CLIENTS-1:0]           c_write,
  input  logic [N_CLIENTS*MS_ADDR_W-1:0] c_addr,
  input  logic [N_CLIENTS*MS_DATA_W-1:0] c_data,
  input  logic [N_CLIENTS*CID_W-1:0]     c_id,
  output logic [N_CLIENTS-1:0]           r_valid,
  input  logic [N_CLIENTS-1:0]           r_taken,
  output logic [MS_DATA_W-1:0]           r_data,
  output logic [CID_W-1:0]               r_id,
  MemoryBus.Master                       bus
`ifdef ARB_STATS_EN
  ,
  output logic [N_CLIENTS*16-1:0]        stat_grants,
  output logic [15:0]                    stat_drops
`endif
);

  logic [MS_ADDR_W-1:0] addr_arr [N_CLIENTS];
  logic [MS_DATA_W-1:0] data_arr [N_CLIENTS];
  logic [CID_W-1:0]     cid_arr  [N_CLIENTS];

  logic [SRC_W-1:0] rr_last_reg;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_valid;
  logic             slot_free;
  logic             grant;
  logic             slot_valid_reg;
  req_t             slot_reg;

  logic [SRC_W-1:0]     sm_src;
  logic                 sm_drop;
  logic                 sm_accept;
  logic                 resp_drain;
  logic                 resp_valid_reg;
  logic [SRC_W-1:0]     resp_src_reg;
  logic [MS_DATA_W-1:0] resp_data_reg;
  logic [CID_W-1:0]     resp_id_reg;

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
    assign addr_arr[gi] = c_addr[gi*MS_ADDR_W +: MS_ADDR_W];
    assign data_arr[gi] = c_data[gi*MS_DATA_W +: MS_DATA_W];
    assign cid_arr[gi]  = c_id[gi*CID_W +: CID_W];
  end

  rr_picker #(
    .N     (N_CLIENTS),
    .IDX_W (SRC_W)
  ) u_picker (
    .req         (c_valid),
    .last        (rr_last_reg),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // A grant may happen whenever the slot is empty or is being emptied this cycle.
  assign slot_free = !slot_valid_reg || bus.msTaken;
  assign grant     = !rst && slot_free && pick_valid;

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_taken
    assign c_taken[gi] = grant && (pick_idx == SRC_W'(gi));
  end

  // Request slot: load on grant (also covers same-cycle drain), clear on drain alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_reg <= 1'b0;
      rr_last_reg    <= SRC_W'(N_CLIENTS - 1);
    end else if (grant) begin
      slot_valid_reg <= 1'b1;
      slot_reg.write <= c_write[pick_idx];
      slot_reg.addr  <= addr_arr[pick_idx];
      slot_reg.data  <= data_arr[pick_idx];
      slot_reg.id    <= {2'b00, pick_idx, cid_arr[pick_idx]};
      rr_last_reg    <= pick_idx;
    end else if (bus.msTaken) begin
      slot_valid_reg <= 1'b0;
    end
  end

  assign bus.msValid   = slot_valid_reg;
  assign bus.msWrite   = slot_reg.write;
  assign bus.msAddress = slot_reg.addr;
  assign bus.msData    = slot_reg.data;
  assign bus.msID      = slot_reg.id;

  // Responses with a foreign prefix or an unknown source are swallowed, never stalled.
  assign sm_src      = bus.smID[AXI_ID_W-1:CID_W];
  assign sm_drop     = (bus.smID[MS_ID_W-1:AXI_ID_W] != '0) ||
                       (32'(sm_src) >= 32'(N_CLIENTS));
  assign resp_drain  = resp_valid_reg && r_taken[resp_src_reg];
  assign bus.smTaken = !rst && bus.smValid && (sm_drop || !resp_valid_reg || resp_drain);
  assign sm_accept   = bus.smTaken && !sm_drop;

  // Response slot: reload on accept (drain in the same cycle leaves no bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
    end else if (sm_accept) begin
      resp_valid_reg <= 1'b1;
      resp_src_reg   <= sm_src;
      resp_data_reg  <= bus.smData;
      resp_id_reg    <= bus.smID[CID_W-1:0];
    end else if (resp_drain) begin
      resp_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_rvalid
    assign r_valid[gi] = resp_valid_reg && (resp_src_reg == SRC_W'(gi));
  end

  assign r_data = resp_data_reg;
  assign r_id   = resp_id_reg;

`ifdef ARB_STATS_EN
  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_grant_cnt
    logic [15:0] cnt_reg;
    // Per-client grant counter, saturating.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (c_taken[gi] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign stat_grants[gi*16 +: 16] = cnt_reg;
  end

  logic [15:0] drop_cnt_reg;
  // Dropped-response counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (bus.smTaken && sm_drop && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end
  assign stat_drops = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter: directed scenarios plus randomized traffic
// checked against queue-based reference models of the request and response paths.
module tb_memory_bus_arbiter;
  import memory_bus_pkg::*;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    c_valid;
  logic [N-1:0]    c_taken;
  logic [N-1:0]    c_write;
  logic [N*30-1:0] c_addr;
  logic [N*24-1:0] c_data;
  logic [N*4-1:0]  c_id;
  logic [N-1:0]    r_valid;
  logic [N-1:0]    r_taken;
  logic [23:0]     r_data;
  logic [3:0]      r_id;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_drops;
`endif

  MemoryBus bus ();

  memory_bus_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .c_valid (c_valid),
    .c_taken (c_taken),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_id    (c_id),
    .r_valid (r_valid),
    .r_taken (r_taken),
    .r_data  (r_data),
    .r_id    (r_id),
    .bus     (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_drops  (stat_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        write;
    logic [29:0] addr;
    logic [23:0] data;
    logic [7:0]  id;
  } exp_req_t;

  typedef struct {
    int          src;
    logic [3:0]  id;
    logic [23:0] data;
  } exp_resp_t;

  task automatic drive_idle();
    c_valid = '0; c_write = '0; c_addr = '0; c_data = '0; c_id = '0; r_taken = '0;
    bus.msTaken = 1'b0; bus.smValid = 1'b0; bus.smData = '0; bus.smID = '0;
  endtask

  // Leaves the bench at a falling edge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; c_valid = '1; bus.smValid = 1'b1; bus.smID = 8'h10; bus.msTaken = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (c_taken !== 4'b0000) $display("FAIL reset_c_taken got=%b exp=0000", c_taken); else passed++;
    checks++; if (bus.msValid !== 1'b0) $display("FAIL reset_msValid got=%b exp=0", bus.msValid); else passed++;
    checks++; if (bus.smTaken !== 1'b0) $display("FAIL reset_smTaken got=%b exp=0", bus.smTaken); else passed++;
    checks++; if (r_valid !== 4'b0000) $display("FAIL reset_r_valid got=%b exp=0000", r_valid); else passed++;
    $display("reset: c_taken=%b msValid=%b smTaken=%b r_valid=%b", c_taken, bus.msValid, bus.smTaken, r_valid);
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int         exp_g  [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_id [5] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h00};
    logic [3:0] exp_t;
    do_reset();
    c_valid = 4'hF; bus.msTaken = 1'b1;
    for (int i = 0; i < N; i++) c_addr[i*30 +: 30] = 30'h1000 + 30'(i);
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (cyc < 5) begin
        exp_t = 4'(1 << exp_g[cyc]);
        checks++; if (c_taken !== exp_t) $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, c_taken, exp_t); else passed++;
      end
      if (cyc > 0) begin
        checks++;
        if (bus.msValid !== 1'b1 || bus.msID !== exp_id[cyc-1])
          $display("FAIL rr_msID cyc=%0d got=%b/%h exp=1/%h", cyc, bus.msValid, bus.msID, exp_id[cyc-1]);
        else passed++;
      end
      $display("rr cyc=%0d c_taken=%b msValid=%b msID=%h", cyc, c_taken, bus.msValid, bus.msID);
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_hold();
    logic [3:0] exp_t;
    do_reset();
    c_valid = 4'b0100; c_id[8 +: 4] = 4'h5; c_addr[60 +: 30] = 30'h100; bus.msTaken = 1'b0;
    #1;
    checks++; if (c_taken !== 4'b0100) $display("FAIL hold_grant got=%b exp=0100", c_taken); else passed++;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 4) bus.msTaken = 1'b1;
      #1;
      exp_t = (cyc == 4) ? 4'b0100 : 4'b0000;
      checks++;
      if (bus.msValid !== 1'b1 || bus.msAddress !== 30'h100 || bus.msID !== 8'h25 || bus.msWrite !== 1'b0)
        $display("FAIL hold_slot cyc=%0d got=%b/%h/%h exp=1/100/25", cyc, bus.msValid, bus.msAddress, bus.msID);
      else passed++;
      checks++; if (c_taken !== exp_t) $display("FAIL hold_taken cyc=%0d got=%b exp=%b", cyc, c_taken, exp_t); else passed++;
      $display("hold cyc=%0d msValid=%b addr=%h msID=%h c_taken=%b", cyc, bus.msValid, bus.msAddress, bus.msID, c_taken);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_response();
    do_reset();
    bus.smValid = 1'b1; bus.smID = 8'h1A; bus.smData = 24'hABCDEF;
    #1;
    checks++; if (bus.smTaken !== 1'b1) $display("FAIL resp_smTaken got=%b exp=1", bus.smTaken); else passed++;
    @(negedge clk);
    bus.smValid = 1'b0;
    #1;
    checks++;
    if (r_valid !== 4'b0010 || r_id !== 4'hA || r_data !== 24'hABCDEF)
      $display("FAIL resp_out got=%b/%h/%h exp=0010/a/abcdef", r_valid, r_id, r_data);
    else passed++;
    $display("resp: r_valid=%b r_id=%h r_data=%h", r_valid, r_id, r_data);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.smValid = 1'b1; bus.smID = 8'h1A; bus.smData = 24'hABCDEF;
    @(negedge clk);
    bus.smID = 8'h1B; bus.smData = 24'h123456; r_taken = 4'b1101;
    for (int cyc = 0; cyc < 2; cyc++) begin
      #1;
      checks++; if (bus.smTaken !== 1'b0) $display("FAIL bp_stall cyc=%0d got=%b exp=0", cyc, bus.smTaken); else passed++;
      checks++;
      if (r_valid !== 4'b0010 || r_id !== 4'hA) $display("FAIL bp_hold cyc=%0d got=%b/%h exp=0010/a", cyc, r_valid, r_id);
      else passed++;
      $display("bp cyc=%0d smTaken=%b r_valid=%b r_id=%h", cyc, bus.smTaken, r_valid, r_id);
      @(negedge clk);
    end
    r_taken = 4'b0010;
    #1;
    checks++; if (bus.smTaken !== 1'b1) $display("FAIL bp_release got=%b exp=1", bus.smTaken); else passed++;
    @(negedge clk);
    r_taken = 4'b0000; bus.smValid = 1'b0;
    #1;
    checks++;
    if (r_valid !== 4'b0010 || r_id !== 4'hB || r_data !== 24'h123456)
      $display("FAIL bp_second got=%b/%h/%h exp=0010/b/123456", r_valid, r_id, r_data);
    else passed++;
    $display("bp second: r_valid=%b r_id=%h r_data=%h", r_valid, r_id, r_data);
    r_taken = 4'b0010;
    @(negedge clk);
    r_taken = 4'b0000;
    #1;
    checks++; if (r_valid !== 4'b0000) $display("FAIL bp_drain got=%b exp=0000", r_valid); else passed++;
  endtask

  task automatic test_drop();
    do_reset();
    bus.smValid = 1'b1; bus.smID = 8'h45; bus.smData = 24'h777777;
    #1;
    checks++; if (bus.smTaken !== 1'b1) $display("FAIL drop_taken got=%b exp=1", bus.smTaken); else passed++;
    @(negedge clk);
    bus.smID = 8'h2C; bus.smData = 24'h0000C0;
    #1;
    checks++; if (r_valid !== 4'b0000) $display("FAIL drop_r_valid got=%b exp=0000", r_valid); else passed++;
    @(negedge clk);
    bus.smID = 8'hC1;
    #1;
    checks++; if (bus.smTaken !== 1'b1) $display("FAIL drop_full_taken got=%b exp=1", bus.smTaken); else passed++;
    @(negedge clk);
    bus.smValid = 1'b0;
    #1;
    checks++;
    if (r_valid !== 4'b0100 || r_id !== 4'hC || r_data !== 24'h0000C0)
      $display("FAIL drop_keep got=%b/%h/%h exp=0100/c/0000c0", r_valid, r_id, r_data);
    else passed++;
`ifdef ARB_STATS_EN
    checks++; if (stat_drops !== 16'd2) $display("FAIL drop_stat got=%0d exp=2", stat_drops); else passed++;
`endif
    $display("drop: r_valid=%b r_id=%h", r_valid, r_id);
  endtask

  task automatic test_reset_midop();
    do_reset();
    c_valid = 4'b0010; bus.msTaken = 1'b0;
    bus.smValid = 1'b1; bus.smID = 8'h31; bus.smData = 24'h5A5A5A;
    @(negedge clk);
    c_valid = '0; bus.smValid = 1'b0;
    #1;
    checks++;
    if (bus.msValid !== 1'b1 || r_valid !== 4'b1000) $display("FAIL midop_full got=%b/%b exp=1/1000", bus.msValid, r_valid);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.msValid !== 1'b0 || r_valid !== 4'b0000) $display("FAIL midop_clear got=%b/%b exp=0/0000", bus.msValid, r_valid);
    else passed++;
    rst = 1'b0; c_valid = 4'hF; bus.msTaken = 1'b1;
    #1;
    checks++; if (c_taken !== 4'b0001) $display("FAIL midop_first got=%b exp=0001", c_taken); else passed++;
    $display("midop: msValid=%b r_valid=%b c_taken=%b", bus.msValid, r_valid, c_taken);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random_req();
    exp_req_t   q[$];
    exp_req_t   e;
    exp_req_t   front;
    int         last;
    int         g;
    int         idx;
    bit         free_slot;
    logic [3:0] exp_t;
    int         grants [N];
    do_reset();
    last = N - 1;
    for (int i = 0; i < N; i++) grants[i] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      c_valid = 4'($urandom); c_write = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        c_addr[i*30 +: 30] = 30'($urandom);
        c_data[i*24 +: 24] = 24'($urandom);
        c_id[i*4 +: 4]     = 4'($urandom);
      end
      bus.msTaken = ($urandom_range(0, 3) != 0);
      #1;
      free_slot = (q.size() == 0) || bus.msTaken;
      g = -1;
      if (free_slot) begin
        for (int k = 1; k <= N; k++) begin
          idx = (last + k) % N;
          if (g < 0 && c_valid[idx]) g = idx;
        end
      end
      exp_t = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (c_taken !== exp_t) $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, c_taken, exp_t); else passed++;
      checks++;
      if (bus.msValid !== (q.size() != 0)) $display("FAIL rnd_msValid cyc=%0d got=%b exp=%b", cyc, bus.msValid, q.size() != 0);
      else passed++;
      if (q.size() != 0) begin
        front = q[0];
        checks++;
        if (bus.msWrite !== front.write || bus.msAddress !== front.addr || bus.msData !== front.data || bus.msID !== front.id)
          $display("FAIL rnd_req cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", cyc, bus.msWrite, bus.msAddress, bus.msData, bus.msID,
                   front.write, front.addr, front.data, front.id);
        else passed++;
      end
      if (bus.msTaken && q.size() != 0) void'(q.pop_front());
      if (g >= 0) begin
        e.write = c_write[g];
        e.addr  = c_addr[g*30 +: 30];
        e.data  = c_data[g*24 +: 24];
        e.id    = {2'b00, 2'(g), c_id[g*4 +: 4]};
        q.push_back(e);
        last = g;
        grants[g]++;
      end
      $display("rnd_req cyc=%0d c_valid=%b c_taken=%b msValid=%b msID=%h", cyc, c_valid, c_taken, bus.msValid, bus.msID);
      @(negedge clk);
    end
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stat_grants[i*16 +: 16] !== 16'(grants[i])) $display("FAIL rnd_stat_grant c=%0d got=%0d exp=%0d", i, stat_grants[i*16 +: 16], grants[i]);
      else passed++;
    end
`endif
    drive_idle();
  endtask

  task automatic test_random_resp();
    exp_resp_t  q[$];
    exp_resp_t  e;
    int         src;
    int         drops;
    bit         drop;
    bit         exp_tk;
    logic [3:0] exp_rv;
    do_reset();
    drops = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      bus.smValid = ($urandom_range(0, 2) != 0);
      bus.smData  = 24'($urandom);
      if ($urandom_range(0, 5) == 0) bus.smID = 8'($urandom);
      else bus.smID = {2'b00, 6'($urandom)};
      r_taken = 4'($urandom);
      #1;
      src    = int'(bus.smID[5:4]);
      drop   = (bus.smID[7:6] != 2'b00) || (src >= N);
      exp_tk = bus.smValid && (drop || q.size() == 0 || r_taken[q[0].src]);
      exp_rv = (q.size() != 0) ? 4'(1 << q[0].src) : 4'b0000;
      checks++; if (bus.smTaken !== exp_tk) $display("FAIL rnd_smTaken cyc=%0d got=%b exp=%b", cyc, bus.smTaken, exp_tk); else passed++;
      checks++; if (r_valid !== exp_rv) $display("FAIL rnd_r_valid cyc=%0d got=%b exp=%b", cyc, r_valid, exp_rv); else passed++;
      if (q.size() != 0) begin
        checks++;
        if (r_id !== q[0].id || r_data !== q[0].data)
          $display("FAIL rnd_resp cyc=%0d got=%h/%h exp=%h/%h", cyc, r_id, r_data, q[0].id, q[0].data);
        else passed++;
      end
      if (q.size() != 0 && r_taken[q[0].src]) void'(q.pop_front());
      if (exp_tk && drop) drops++;
      if (exp_tk && !drop) begin
        e.src  = src;
        e.id   = bus.smID[3:0];
        e.data = bus.smData;
        q.push_back(e);
      end
      $display("rnd_resp cyc=%0d smValid=%b smID=%h smTaken=%b r_valid=%b", cyc, bus.smValid, bus.smID, bus.smTaken, r_valid);
      @(negedge clk);
    end
`ifdef ARB_STATS_EN
    checks++; if (stat_drops !== 16'(drops)) $display("FAIL rnd_stat_drops got=%0d exp=%0d", stat_drops, drops); else passed++;
`endif
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_round_robin();
    test_hold();
    test_response();
    test_backpressure();
    test_drop();
    test_reset_midop();
    test_random_req();
    test_random_resp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
